// File: rtl/adc_ser_pkg.sv
// Shared definitions for the ADC LVDS frame emulator: sample width,
// test-pattern encodings (shared with the deserializer side) and FSM states.
package adc_ser_pkg;

    localparam int unsigned ADC_BITS = 12;
    localparam int unsigned N_LANES  = 4;

    typedef enum logic [1:0] {
        PAT_PASS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_MID   = 2'd3
    } pat_e;

    // Loading happens on the boundary cycle itself (IDLE at ph=1, or the last
    // SHIFT cycle), so no separate registered LOAD state is needed.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic logic checker_bit(input int unsigned idx, input logic inverted);
        return (idx % 2 == 1) ^ inverted;
    endfunction

endpackage

// File: rtl/adc_ser_lane.sv
// One serial data lane: parallel load of a BITS-wide word, MSB-first shift out.
module adc_ser_lane #(
    parameter int unsigned BITS = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            shift,
    input  logic [BITS-1:0] word,
    output logic            dat
);

    logic [BITS-1:0] sr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= word;
        end else if (shift) begin
            sr <= {sr[BITS-2:0], 1'b0};
        end
    end

    assign dat = sr[BITS-1];

endmodule

// File: rtl/adc_ser.sv
// ADC LVDS frame emulator: serializes four sample lanes (or built-in patterns)
// into frame clock, data clock and four MSB-first data lanes.
module adc_ser
    import adc_ser_pkg::*;
#(
    parameter int unsigned     BITS     = ADC_BITS,
    parameter logic [BITS-1:0] MIDSCALE = 12'h800
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [1:0]      pattern_mode,
    input  logic            sample_valid,
    output logic            sample_ready,
    input  logic [BITS-1:0] sample_a,
    input  logic [BITS-1:0] sample_b,
    input  logic [BITS-1:0] sample_c,
    input  logic [BITS-1:0] sample_d,
    output logic [15:0]     frame_count,
    output logic            underflow,
    output logic            adc_fco,
    output logic            adc_dco,
    output logic            adc_dat_a,
    output logic            adc_dat_b,
    output logic            adc_dat_c,
    output logic            adc_dat_d
);

    localparam int unsigned IDX_W = $clog2(BITS);

    state_e          state, state_d;
    pat_e            mode;
    logic            ph;
    logic [IDX_W-1:0] bit_idx;
    logic [BITS-1:0] ramp;
    logic            chk_inv;
    logic            last;
    logic            load;
    logic            shift;
    logic [BITS-1:0] samp    [N_LANES];
    logic [BITS-1:0] word    [N_LANES];
    logic [BITS-1:0] chk_word;
    logic [N_LANES-1:0] dat;

    assign mode    = pat_e'(pattern_mode);
    assign samp[0] = sample_a;
    assign samp[1] = sample_b;
    assign samp[2] = sample_c;
    assign samp[3] = sample_d;

    always_comb begin
        last         = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        sample_ready = 1'b0;
        underflow    = 1'b0;
        state_d      = state;
        case (state)
            IDLE: begin
                load = enable && ph;
            end
            SHIFT: begin
                last  = ph && (bit_idx == IDX_W'(BITS - 1));
                load  = last && enable;
                shift = ph && !load;
            end
            default: ;
        endcase
        if (load) begin
            state_d = SHIFT;
        end else if (last) begin
            state_d = IDLE;
        end
        sample_ready = load && (mode == PAT_PASS);
        underflow    = sample_ready && !sample_valid;
    end

    always_comb begin
        chk_word = '0;
        for (int unsigned i = 0; i < BITS; i++) begin
            chk_word[i] = checker_bit(i, chk_inv);
        end
        for (int unsigned i = 0; i < N_LANES; i++) begin
            word[i] = MIDSCALE;
            case (mode)
                PAT_PASS:  word[i] = sample_valid ? samp[i] : MIDSCALE;
                PAT_RAMP:  word[i] = ramp + BITS'(i);
                PAT_CHECK: word[i] = chk_word;
                default:   word[i] = MIDSCALE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ph          <= 1'b0;
            bit_idx     <= '0;
            adc_fco     <= 1'b0;
            frame_count <= '0;
            ramp        <= '0;
            chk_inv     <= 1'b0;
        end else begin
            state <= state_d;
            ph    <= ~ph;
            if (load) begin
                bit_idx <= '0;
                adc_fco <= 1'b1;
            end else if (last) begin
                bit_idx <= '0;
                adc_fco <= 1'b0;
            end else if (shift) begin
                bit_idx <= bit_idx + 1'b1;
                adc_fco <= (bit_idx < IDX_W'(BITS / 2 - 1));
            end
            if (last) begin
                frame_count <= frame_count + 16'd1;
            end
            if (load && mode == PAT_RAMP) begin
                ramp <= ramp + BITS'(4);
            end
            if (load && mode == PAT_CHECK) begin
                chk_inv <= ~chk_inv;
            end
        end
    end

    assign adc_dco = ph;

    // On a final shift without reload the registers drain to zero, leaving IDLE lanes low.
    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        adc_ser_lane #(.BITS(BITS)) u_lane (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .shift (shift),
            .word  (word[g]),
            .dat   (dat[g])
        );
    end

    assign adc_dat_a = dat[0];
    assign adc_dat_b = dat[1];
    assign adc_dat_c = dat[2];
    assign adc_dat_d = dat[3];

endmodule
